ripple_carry_adder: RTL and testbench
=====================================

Name: ripple_carry_adder

Overview:
- Parameterised unsigned binary adder built as a chain of WIDTH one-bit full-adder cells; carry ripples from bit 0 to bit WIDTH-1.
- Primary result (sum, cout) is purely combinational from a, b, cin.
- A registered copy of the result, plus a signed-overflow flag, is provided for synchronous consumers.
- Used as a leaf arithmetic block in datapaths.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range >= 1.

Ports:
- clk  input  1  system clock; rising edge active; used only by the registered outputs.
- rst  input  1  synchronous, active-high reset; affects only the registered outputs.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry into bit 0.
- sum  output  WIDTH  combinational sum bits, equal to (a+b+cin) mod 2^WIDTH.
- cout  output  1  combinational carry out of bit WIDTH-1.
- ovf  output  1  combinational two's-complement overflow: carry into MSB XOR carry out of MSB.
- sum_q  output  WIDTH  registered sum.
- cout_q  output  1  registered cout.
- ovf_q  output  1  registered ovf.

Behaviour:
- Combinational path:
  - {cout, sum} == a + b + cin, evaluated at WIDTH+1 bits, for every input combination.
  - Zero clock latency; outputs depend on no state and are unaffected by clk or rst.
  - Bit i: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]); c[0] = cin; cout = c[WIDTH].
  - Must be a true ripple structure. No carry-lookahead and no behavioural "+" at the top level.
- Overflow:
  - ovf = c[WIDTH-1] ^ c[WIDTH].
  - For WIDTH == 1: c[0] is cin, so ovf = cin ^ cout.
- Registered path:
  - On each rising clk edge, if rst == 1: sum_q = 0, cout_q = 0, ovf_q = 0.
  - Otherwise sum_q/cout_q/ovf_q capture sum/cout/ovf. Latency is exactly 1 cycle, with no enable.
  - Reset asserted mid-stream clears the registers on that edge. The combinational outputs keep tracking the inputs.
  - The registered outputs are undefined before the first clock edge. They are defined after any edge with rst high.
- Boundary conditions:
  - All-ones + all-ones + 1: sum all ones, cout 1.
  - 0 + 0 + 0: all zero.
  - Wrap-around is modulo 2^WIDTH, with the carry exported on cout.
- X-propagation:
  - No X-masking logic is added.
  - X on an input bit may propagate up the carry chain from that bit.

Decomposition:
- No shared package is required; WIDTH is the only configuration.
- One sub-module, full_adder (inputs a, b, ci; outputs s, co), instantiated WIDTH times with a generate loop.
- Carries are held in an internal WIDTH+1 bit vector.
- The output register is inline in ripple_carry_adder.

Test Plan:
- Exhaustive, WIDTH=4: all 16x16x2 combinations of a, b, cin, checked 10 ns after each change. {cout,sum} == a+b+cin; 512 tests, 0 errors.
- Corner values: a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1. a=4'h0, b=4'h0, cin=0 -> sum=0, cout=0. a=4'hF, b=4'h0, cin=1 -> sum=0, cout=1.
- Signed overflow: a=4'h7, b=4'h1, cin=0 -> sum=4'h8, ovf=1, cout=0. a=4'h8, b=4'h8, cin=0 -> sum=0, ovf=1, cout=1. a=4'h3, b=4'h2 -> ovf=0.
- Registered latency: rst=1 for 2 cycles -> sum_q=0, cout_q=0, ovf_q=0. Release, then apply a=4'h9, b=4'h8, cin=1 -> after the next rising edge sum_q=4'h2, cout_q=1.
- Reset mid-stream: with sum_q nonzero, assert rst for one edge -> sum_q/cout_q/ovf_q = 0 on that edge while sum/cout still show a+b+cin. Deassert -> registers track again after one edge.
- Width sweep: WIDTH=1 and WIDTH=8 with random vectors (>=1000) -> {cout,sum}==a+b+cin. For WIDTH=1, ovf == cin^cout.

Source files
------------

// File: rtl/ripple_carry_adder_pkg.sv
// Shared configuration for the ripple-carry adder slice.
package ripple_carry_adder_pkg;

    localparam int unsigned RCA_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// One-bit full-adder cell; the ripple chain in ripple_carry_adder is built from these.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// Unsigned ripple-carry adder: combinational sum/cout/ovf plus a one-cycle registered copy.
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q
);

    // c[i] is the carry into bit i; c[WIDTH] leaves the MSB.
    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[WIDTH];
    // For WIDTH == 1, c[0] is cin, so this reduces to cin ^ cout.
    assign ovf  = c[WIDTH-1] ^ c[WIDTH];

    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;

    always_comb begin
        sum_d  = sum;
        cout_d = cout;
        ovf_d  = ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed/exhaustive bench for ripple_carry_adder at WIDTH 4, plus random sweeps at WIDTH 1 and 8.
module tb_ripple_carry_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] a4, b4;
    logic       cin4;
    logic [3:0] sum4, sum4_q;
    logic       cout4, ovf4, cout4_q, ovf4_q;

    logic [0:0] a1, b1;
    logic       cin1;
    logic [0:0] sum1, sum1_q;
    logic       cout1, ovf1, cout1_q, ovf1_q;

    logic [7:0] a8, b8;
    logic       cin8;
    logic [7:0] sum8, sum8_q;
    logic       cout8, ovf8, cout8_q, ovf8_q;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ripple_carry_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4),
        .sum(sum4), .cout(cout4), .ovf(ovf4),
        .sum_q(sum4_q), .cout_q(cout4_q), .ovf_q(ovf4_q)
    );

    ripple_carry_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1),
        .sum(sum1), .cout(cout1), .ovf(ovf1),
        .sum_q(sum1_q), .cout_q(cout1_q), .ovf_q(ovf1_q)
    );

    ripple_carry_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .cout(cout8), .ovf(ovf8),
        .sum_q(sum8_q), .cout_q(cout8_q), .ovf_q(ovf8_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] exp5;
        logic [1:0] exp2;
        logic [8:0] exp9;
        int         r;
        logic       ovf_exp;

        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        a8 = 8'h0; b8 = 8'h0; cin8 = 1'b0;

        // Reset held for two edges.
        @(posedge clk); @(posedge clk); #1;
        chk("rst_sum_q",  {28'b0, sum4_q},  32'h0);
        chk("rst_cout_q", {31'b0, cout4_q}, 32'h0);
        chk("rst_ovf_q",  {31'b0, ovf4_q},  32'h0);

        // Corner values.
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; #10;
        chk("ff1_sum", {28'b0, sum4}, 32'hF);
        chk("ff1_cout", {31'b0, cout4}, 32'h1);
        chk("ff1_ovf", {31'b0, ovf4}, 32'h0);
        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0; #10;
        chk("zero_sum", {28'b0, sum4}, 32'h0);
        chk("zero_cout", {31'b0, cout4}, 32'h0);
        a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1; #10;
        chk("wrap_sum", {28'b0, sum4}, 32'h0);
        chk("wrap_cout", {31'b0, cout4}, 32'h1);

        // Signed overflow.
        a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0; #10;
        chk("ovf71_sum", {28'b0, sum4}, 32'h8);
        chk("ovf71_ovf", {31'b0, ovf4}, 32'h1);
        chk("ovf71_cout", {31'b0, cout4}, 32'h0);
        a4 = 4'h8; b4 = 4'h8; cin4 = 1'b0; #10;
        chk("ovf88_sum", {28'b0, sum4}, 32'h0);
        chk("ovf88_ovf", {31'b0, ovf4}, 32'h1);
        chk("ovf88_cout", {31'b0, cout4}, 32'h1);
        a4 = 4'h3; b4 = 4'h2; cin4 = 1'b0; #10;
        chk("ovf32_ovf", {31'b0, ovf4}, 32'h0);
        chk("ovf32_sum", {28'b0, sum4}, 32'h5);

        // Registered latency after reset release.
        @(negedge clk);
        rst = 1'b0;
        a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1;
        @(posedge clk); #1;
        chk("reg_sum_q", {28'b0, sum4_q}, 32'h2);
        chk("reg_cout_q", {31'b0, cout4_q}, 32'h1);
        chk("reg_ovf_q", {31'b0, ovf4_q}, 32'h1);

        // Mid-stream reset clears registers only.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_sum_q", {28'b0, sum4_q}, 32'h0);
        chk("mid_cout_q", {31'b0, cout4_q}, 32'h0);
        chk("mid_ovf_q", {31'b0, ovf4_q}, 32'h0);
        chk("mid_sum", {28'b0, sum4}, 32'h2);
        chk("mid_cout", {31'b0, cout4}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_sum_q", {28'b0, sum4_q}, 32'h2);
        chk("rel_cout_q", {31'b0, cout4_q}, 32'h1);

        // Next input captured exactly one edge later.
        @(negedge clk);
        a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0;
        #1;
        chk("lat_hold_sum_q", {28'b0, sum4_q}, 32'h2);
        @(posedge clk); #1;
        chk("lat_sum_q", {28'b0, sum4_q}, 32'h8);
        chk("lat_ovf_q", {31'b0, ovf4_q}, 32'h1);
        chk("lat_cout_q", {31'b0, cout4_q}, 32'h0);

        // Exhaustive WIDTH=4.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                for (int k = 0; k < 2; k++) begin
                    a4 = 4'(i); b4 = 4'(j); cin4 = 1'(k);
                    #10;
                    exp5 = 5'(i + j + k);
                    r = $signed(a4) + $signed(b4) + k;
                    ovf_exp = (r > 7) || (r < -8);
                    chk("ex4_sum", {27'b0, cout4, sum4}, {27'b0, exp5});
                    chk("ex4_ovf", {31'b0, ovf4}, {31'b0, ovf_exp});
                end
            end
        end

        // Random sweeps at WIDTH=1 and WIDTH=8.
        for (int n = 0; n < 1000; n++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            #10;
            exp2 = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
            chk("w1_sum", {30'b0, cout1, sum1}, {30'b0, exp2});
            chk("w1_ovf", {31'b0, ovf1}, {31'b0, cin1 ^ exp2[1]});
            exp9 = {1'b0, a8} + {1'b0, b8} + {8'b0, cin8};
            chk("w8_sum", {23'b0, cout8, sum8}, {23'b0, exp9});
            r = $signed(a8) + $signed(b8) + int'(cin8);
            ovf_exp = (r > 127) || (r < -128);
            chk("w8_ovf", {31'b0, ovf8}, {31'b0, ovf_exp});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
